// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between an instruction-fetch
// requester and a data requester, with a per-transaction busy timeout.
module mem_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int BYTE_DATA_WIDTH = 4,
  parameter int TIMEOUT_CYCLES  = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       inst_req,
  input  logic [DATA_WIDTH-1:0]      inst_addr,
  output logic                       inst_valid,
  output logic [DATA_WIDTH-1:0]      inst_data,
  input  logic                       data_req,
  input  logic                       data_we,
  input  logic [BYTE_DATA_WIDTH-1:0] byte_enable,
  input  logic [DATA_WIDTH-1:0]      data_addr,
  input  logic [DATA_WIDTH-1:0]      wdata,
  output logic                       data_valid,
  output logic [DATA_WIDTH-1:0]      rdata,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [BYTE_DATA_WIDTH-1:0] mem_byte_enable,
  output logic [DATA_WIDTH-1:0]      mem_addr,
  output logic [DATA_WIDTH-1:0]      mem_wdata,
  input  logic                       mem_valid,
  input  logic [DATA_WIDTH-1:0]      mem_rdata,
  output logic                       bus_error
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INST_BUSY = 2'd1,
    DATA_BUSY = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_INST = 1'b0,
    GRANT_DATA = 1'b1
  } grant_t;

  localparam bit         TIMEOUT_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] TIMEOUT_LAST = TIMEOUT_EN ? 8'(TIMEOUT_CYCLES - 1) : 8'd0;

  state_t          state;
  grant_t          last_grant;
  logic [7:0]      busy_cnt;
  logic            in_busy;
  logic            timeout_hit;
  logic            done;
  logic            pick_data;
  logic [DATA_WIDTH-1:0] resp_data;

  assign in_busy     = (state == INST_BUSY) || (state == DATA_BUSY);
  assign timeout_hit = TIMEOUT_EN && in_busy && !mem_valid && (busy_cnt == TIMEOUT_LAST);
  assign done        = in_busy && (mem_valid || timeout_hit);
  // A timed-out transaction completes with zero data; a real response wins the tie.
  assign resp_data   = mem_valid ? mem_rdata : '0;
  assign bus_error   = timeout_hit;

  // On a tie the data side wins unless it was the last one served.
  assign pick_data   = data_req && (!inst_req || (last_grant == GRANT_INST));

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    inst_valid = 1'b0;
    inst_data  = '0;
    data_valid = 1'b0;
    rdata      = '0;
    if (done && (state == INST_BUSY)) begin
      inst_valid = 1'b1;
      inst_data  = resp_data;
    end
    if (done && (state == DATA_BUSY)) begin
      data_valid = 1'b1;
      rdata      = resp_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      last_grant      <= GRANT_INST;
      busy_cnt        <= 8'd0;
      mem_req         <= 1'b0;
      mem_we          <= 1'b0;
      mem_byte_enable <= '0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (inst_req || data_req) begin
            busy_cnt <= 8'd0;
            mem_req  <= 1'b1;
            if (pick_data) begin
              state           <= DATA_BUSY;
              last_grant      <= GRANT_DATA;
              mem_we          <= data_we;
              mem_byte_enable <= byte_enable;
              mem_addr        <= data_addr;
              mem_wdata       <= wdata;
            end else begin
              state           <= INST_BUSY;
              last_grant      <= GRANT_INST;
              mem_we          <= 1'b0;
              mem_byte_enable <= '1;
              mem_addr        <= inst_addr;
              mem_wdata       <= '0;
            end
          end
        end
        INST_BUSY, DATA_BUSY: begin
          if (done) begin
            state   <= RELEASE;
            mem_req <= 1'b0;
          end else begin
            busy_cnt <= busy_cnt + 8'd1;
          end
        end
        RELEASE: begin
          // Requests are ignored here so a requester still holding req is not re-served.
          state <= IDLE;
        end
        default: begin
          state   <= IDLE;
          mem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;

  localparam int DW = 32;
  localparam int BW = 4;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_req;
  logic [DW-1:0] inst_addr;
  logic          inst_valid;
  logic [DW-1:0] inst_data;
  logic          data_req;
  logic          data_we;
  logic [BW-1:0] byte_enable;
  logic [DW-1:0] data_addr;
  logic [DW-1:0] wdata;
  logic          data_valid;
  logic [DW-1:0] rdata;
  logic          mem_req;
  logic          mem_we;
  logic [BW-1:0] mem_byte_enable;
  logic [DW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_valid;
  logic [DW-1:0] mem_rdata;
  logic          bus_error;

  always #5 clk = ~clk;

  mem_arbiter #(
    .DATA_WIDTH      (DW),
    .BYTE_DATA_WIDTH (BW),
    .TIMEOUT_CYCLES  (TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .inst_req        (inst_req),
    .inst_addr       (inst_addr),
    .inst_valid      (inst_valid),
    .inst_data       (inst_data),
    .data_req        (data_req),
    .data_we         (data_we),
    .byte_enable     (byte_enable),
    .data_addr       (data_addr),
    .wdata           (wdata),
    .data_valid      (data_valid),
    .rdata           (rdata),
    .mem_req         (mem_req),
    .mem_we          (mem_we),
    .mem_byte_enable (mem_byte_enable),
    .mem_addr        (mem_addr),
    .mem_wdata       (mem_wdata),
    .mem_valid       (mem_valid),
    .mem_rdata       (mem_rdata),
    .bus_error       (bus_error)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle forward: land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    inst_req    = 1'b0;
    inst_addr   = '0;
    data_req    = 1'b0;
    data_we     = 1'b0;
    byte_enable = '0;
    data_addr   = '0;
    wdata       = '0;
    mem_valid   = 1'b0;
    mem_rdata   = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".mem_req"},    mem_req,         1'b0);
    check({tag, ".mem_we"},     mem_we,          1'b0);
    check({tag, ".mem_be"},     mem_byte_enable, '0);
    check({tag, ".mem_addr"},   mem_addr,        '0);
    check({tag, ".mem_wdata"},  mem_wdata,       '0);
    check({tag, ".inst_valid"}, inst_valid,      1'b0);
    check({tag, ".inst_data"},  inst_data,       '0);
    check({tag, ".data_valid"}, data_valid,      1'b0);
    check({tag, ".rdata"},      rdata,           '0);
    check({tag, ".bus_error"},  bus_error,       1'b0);
  endtask

  // ---------------- randomized traffic with reference model ----------------
  typedef struct {
    logic          line;
    logic          we;
    logic [BW-1:0] be;
    logic [DW-1:0] addr;
    logic [DW-1:0] wdata;
    int            drop_at;
    int            start;
  } rq_t;

  rq_t rq[2];  // 0 = instruction side, 1 = data side

  task automatic run_random(input int ncyc);
    int            owner;    // -1 none, 0 inst, 1 data
    int            last;     // last requester granted
    int            k;        // busy cycle index of the current transaction
    int            lat;      // busy cycle in which memory answers
    int            free_at;  // first cycle a new request can be sampled
    logic          g_we;
    logic [BW-1:0] g_be;
    logic [DW-1:0] g_addr;
    logic [DW-1:0] g_wdata;
    logic [DW-1:0] resp;
    logic          ev;
    logic          eb;
    logic [DW-1:0] ed;
    owner   = -1;
    last    = 0;
    k       = 0;
    lat     = 1;
    free_at = 0;
    g_we    = 1'b0;
    g_be    = '0;
    g_addr  = '0;
    g_wdata = '0;
    for (int r = 0; r < 2; r++) begin
      rq[r].line    = 1'b0;
      rq[r].drop_at = -1;
      rq[r].start   = 0;  // both requesters rise together right after reset
    end
    for (int c = 0; c < ncyc; c++) begin
      for (int r = 0; r < 2; r++) begin
        if (rq[r].line && c == rq[r].drop_at) rq[r].line = 1'b0;
        if (!rq[r].line && c >= rq[r].start) begin
          rq[r].line    = 1'b1;
          rq[r].drop_at = -1;
          rq[r].we      = 1'($urandom_range(0, 1));
          rq[r].be      = BW'($urandom);
          rq[r].addr    = $urandom;
          rq[r].wdata   = $urandom;
        end else if (owner == r) begin
          rq[r].we    = 1'($urandom_range(0, 1));
          rq[r].be    = BW'($urandom);
          rq[r].addr  = $urandom;
          rq[r].wdata = $urandom;
        end
      end
      resp = $urandom;
      if (owner >= 0) begin
        k++;
        mem_valid = (k == lat);
      end else begin
        mem_valid = ($urandom_range(0, 3) == 0);
      end
      mem_rdata   = resp;
      inst_req    = rq[0].line;
      inst_addr   = rq[0].addr;
      data_req    = rq[1].line;
      data_we     = rq[1].we;
      byte_enable = rq[1].be;
      data_addr   = rq[1].addr;
      wdata       = rq[1].wdata;

      check("rnd.mem_req", mem_req, owner >= 0);
      if (owner >= 0) begin
        check("rnd.mem_addr",  mem_addr,        g_addr);
        check("rnd.mem_we",    mem_we,          g_we);
        check("rnd.mem_be",    mem_byte_enable, g_be);
        check("rnd.mem_wdata", mem_wdata,       g_wdata);
      end
      #1;
      ev = 1'b0;
      eb = 1'b0;
      ed = '0;
      if (owner >= 0) begin
        if (k == lat) begin
          ev = 1'b1;
          ed = resp;
        end else if (k == TO) begin
          ev = 1'b1;
          eb = 1'b1;
        end
      end
      check("rnd.inst_valid", inst_valid, ev && owner == 0);
      check("rnd.inst_data",  inst_data,  (ev && owner == 0) ? ed : '0);
      check("rnd.data_valid", data_valid, ev && owner == 1);
      check("rnd.rdata",      rdata,      (ev && owner == 1) ? ed : '0);
      check("rnd.bus_error",  bus_error,  eb);
      if (ev) begin
        // Requester keeps req one extra cycle half the time; it must not be re-served.
        rq[owner].drop_at = ($urandom_range(0, 1) == 1) ? c + 2 : c + 1;
        rq[owner].start   = rq[owner].drop_at + 1 + int'($urandom_range(0, 3));
        free_at = c + 2;
        owner   = -1;
      end
      if (owner < 0 && c >= free_at && (rq[0].line || rq[1].line)) begin
        if (rq[0].line && rq[1].line) owner = (last == 0) ? 1 : 0;
        else                          owner = rq[0].line ? 0 : 1;
        last = owner;
        k    = 0;
        lat  = int'($urandom_range(1, 6));
        if (owner == 0) begin
          g_we    = 1'b0;
          g_be    = '1;
          g_addr  = rq[0].addr;
          g_wdata = '0;
        end else begin
          g_we    = rq[1].we;
          g_be    = rq[1].be;
          g_addr  = rq[1].addr;
          g_wdata = rq[1].wdata;
        end
      end
      step();
    end
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    do_reset();
    check_quiet("reset");

    // Instruction fetch, memory answers on the third busy cycle.
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0100;
    step();
    check("fetch.mem_req",  mem_req,         1'b1);
    check("fetch.mem_addr", mem_addr,        32'h0000_0100);
    check("fetch.mem_be",   mem_byte_enable, 4'hF);
    check("fetch.mem_we",   mem_we,          1'b0);
    check("fetch.mem_wdata", mem_wdata,      32'h0);
    inst_addr = 32'hFFFF_0000;
    mem_rdata = 32'h1111_1111;
    #1;
    check("fetch.wait1", inst_valid, 1'b0);
    step();
    check("fetch.addr_held", mem_addr, 32'h0000_0100);
    #1;
    check("fetch.wait2", inst_valid, 1'b0);
    step();
    mem_valid = 1'b1;
    mem_rdata = 32'h0050_0093;
    #1;
    check("fetch.inst_valid", inst_valid, 1'b1);
    check("fetch.inst_data",  inst_data,  32'h0050_0093);
    check("fetch.data_valid", data_valid, 1'b0);
    check("fetch.bus_error",  bus_error,  1'b0);
    step();
    inst_req  = 1'b0;
    mem_valid = 1'b0;
    check("fetch.release_req", mem_req, 1'b0);
    #1;
    check("fetch.one_pulse", inst_valid, 1'b0);
    step();

    // Data store answered in the first busy cycle.
    data_req    = 1'b1;
    data_we     = 1'b1;
    data_addr   = 32'h0000_2000;
    wdata       = 32'hDEAD_BEEF;
    byte_enable = 4'h3;
    step();
    check("store.mem_req",   mem_req,         1'b1);
    check("store.mem_we",    mem_we,          1'b1);
    check("store.mem_addr",  mem_addr,        32'h0000_2000);
    check("store.mem_wdata", mem_wdata,       32'hDEAD_BEEF);
    check("store.mem_be",    mem_byte_enable, 4'h3);
    mem_valid = 1'b1;
    mem_rdata = 32'hCAFE_0001;
    #1;
    check("store.data_valid", data_valid, 1'b1);
    check("store.rdata",      rdata,      32'hCAFE_0001);
    step();
    data_req  = 1'b0;
    data_we   = 1'b0;
    mem_valid = 1'b0;
    step();

    // Timeout: memory never answers a load.
    data_req  = 1'b1;
    data_addr = 32'h0000_3000;
    step();
    mem_rdata = 32'h5A5A_5A5A;
    for (int i = 1; i < TO; i++) begin
      check("tmo.mem_req", mem_req, 1'b1);
      #1;
      check("tmo.no_valid", data_valid, 1'b0);
      check("tmo.no_error", bus_error,  1'b0);
      step();
    end
    #1;
    check("tmo.data_valid", data_valid, 1'b1);
    check("tmo.rdata",      rdata,      32'h0);
    check("tmo.bus_error",  bus_error,  1'b1);
    step();
    data_req = 1'b0;
    check("tmo.release_req", mem_req, 1'b0);
    #1;
    check("tmo.release_err", bus_error, 1'b0);
    step();
    check("tmo.idle_req", mem_req, 1'b0);

    // Reset in the middle of a fetch abandons it.
    inst_req  = 1'b1;
    inst_addr = 32'h0000_0044;
    step();
    check("rstmid.mem_req", mem_req, 1'b1);
    rst      = 1'b1;
    inst_req = 1'b0;
    #1;
    check_quiet("rstmid");
    step();
    rst       = 1'b0;
    mem_valid = 1'b1;
    mem_rdata = 32'h7777_7777;
    #1;
    check("rstmid.late_valid", inst_valid, 1'b0);
    check("rstmid.late_data",  inst_data,  32'h0);
    step();
    mem_valid = 1'b0;
    check("rstmid.mem_req_off", mem_req, 1'b0);

    do_reset();
    run_random(3000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32: address and data width of all ports.
REQ-002 Parameter BYTE_DATA_WIDTH, default 4: byte-enable width.
REQ-003 Parameter TIMEOUT_CYCLES, default 16, legal range 0..255: busy-cycle limit per transaction; 0 disables the timeout.
REQ-004 Port clk  in  1: single clock; all state updates on its rising edge.
REQ-005 Port rst  in  1: reset, asynchronous, active-high.
REQ-006 Port inst_req  in  1: instruction fetch request, level, held until inst_valid.
REQ-007 Port inst_addr  in  DATA_WIDTH: fetch address.
REQ-008 Port inst_valid  out  1: one-cycle fetch completion pulse.
REQ-009 Port inst_data  out  DATA_WIDTH: fetched word, meaningful only while inst_valid=1.
REQ-010 Port data_req  in  1: data access request, level, held until data_valid.
REQ-011 Ports data_we (in, 1), byte_enable (in, BYTE_DATA_WIDTH), data_addr (in, DATA_WIDTH), wdata (in, DATA_WIDTH): data access attributes.
REQ-012 Port data_valid  out  1: one-cycle data completion pulse.
REQ-013 Port rdata  out  DATA_WIDTH: load data, meaningful only while data_valid=1.
REQ-014 Ports mem_req, mem_we (out, 1), mem_byte_enable (out, BYTE_DATA_WIDTH), mem_addr, mem_wdata (out, DATA_WIDTH): shared memory request.
REQ-015 Ports mem_valid (in, 1), mem_rdata (in, DATA_WIDTH): shared memory response.
REQ-016 Port bus_error  out  1: one-cycle pulse on transaction timeout.

Function
REQ-017 FSM states SHALL be IDLE, INST_BUSY, DATA_BUSY and RELEASE.
REQ-018 IDLE, only inst_req=1: next state INST_BUSY; only data_req=1: next state DATA_BUSY; neither: stay in IDLE.
REQ-019 IDLE, both requests high: grant the requester not granted last (round-robin); the last_grant register resets to "inst", so data wins the first tie after reset.
REQ-020 On grant, register address, we, byte_enable and wdata into holding registers that drive mem_*; the requester's inputs are ignored until completion.
REQ-021 Instruction grant drives mem_we=0, mem_byte_enable=all ones and mem_wdata=0.
REQ-022 mem_req SHALL be registered: high in every BUSY cycle, low in IDLE and RELEASE.
REQ-023 In INST_BUSY, mem_valid=1 gives inst_valid=1 and inst_data=mem_rdata combinationally in the same cycle; next state RELEASE.
REQ-024 In DATA_BUSY, mem_valid=1 gives data_valid=1 and rdata=mem_rdata combinationally in the same cycle, for writes as well as reads; next state RELEASE.
REQ-025 inst_data and rdata SHALL be 0 whenever their valid is low.
REQ-026 RELEASE lasts exactly one cycle, ignores both requests, then goes to IDLE, so a request held one cycle past its valid is not re-served.
REQ-027 Latency: request high in IDLE at cycle N gives mem_req at N+1; mem_valid at cycle M gives requester valid at M; mem_req low at M+1; earliest next grant is sampled at M+2.
REQ-028 mem_valid in IDLE or RELEASE SHALL be ignored, with no valid pulse and no state change.
REQ-029 The 8-bit busy counter clears on grant and increments each BUSY cycle in which mem_valid=0.
REQ-030 Timeout: if TIMEOUT_CYCLES>0 and the counter equals TIMEOUT_CYCLES-1 with mem_valid=0, pulse the granted requester's valid with data 0 and bus_error=1, then go to RELEASE.
REQ-031 If mem_valid=1 in the timeout cycle, it completes normally with no bus_error.
REQ-032 last_grant SHALL update on every grant.

Reset
REQ-033 rst=1 SHALL immediately force state IDLE, last_grant=inst, counter=0, holding registers=0, and mem_req, mem_we, mem_byte_enable, mem_addr, mem_wdata, inst_valid, data_valid, inst_data, rdata and bus_error to 0.
REQ-034 Reset asserted during BUSY SHALL abandon the transaction; a later mem_valid for it is ignored per REQ-028.

Verification
REQ-035 inst_req=1, inst_addr=0x100; mem_valid two cycles after mem_req with mem_rdata=0x00500093 -> mem_addr=0x100, mem_byte_enable=0xF, mem_we=0, one inst_valid pulse with inst_data=0x00500093.
REQ-036 Both requests rise together right after reset -> data granted first; inst granted second, with mem_req rising at cycle M+3 relative to the data mem_valid at M.
REQ-037 data_req store: data_addr=0x2000, wdata=0xDEADBEEF, byte_enable=0x3 -> mem_* fields match, data_valid pulses and rdata equals mem_rdata.
REQ-038 TIMEOUT_CYCLES=4 with mem_valid held low -> on the 4th busy cycle, data_valid=1, rdata=0, bus_error=1; then RELEASE and IDLE.
REQ-039 rst pulsed mid INST_BUSY, then mem_valid=1 -> all outputs 0 and no inst_valid.
REQ-040 Requester holds req one cycle after its valid -> no second grant for it; the other pending requester is served next.
